// File: rtl/median_frame_scheduler.sv
// median_frame_scheduler
//   Sequences the binary median-filter engine one frame at a time: waits for a
//   captured frame, pulses filterInit, holds filterStart until fullImageDone,
//   samples the engine's wakeUp verdict and debounces verdicts across
//   consecutive frames into a sticky wake interrupt for the host FPGA. Also
//   owns the frame-stable threshold register, a per-frame watchdog and the
//   enforced idle gap between frames.
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   enable         scheduling allowed (sampled only in IDLE)
//   frameReady     level: complete binary frame present in memory
//   thresholdIn    new activeWindows threshold
//   thresholdLoad  1-cycle strobe loading thresholdIn (honoured in IDLE only)
//   fullImageDone  engine finished the frame
//   wakeUp         engine's registered above-threshold verdict
//   ackIrq         host strobe clearing fpgaWakeIrq
//   filterInit     engine init
//   filterStart    engine start (low clears the engine's wakeUp)
//   threshold      engine threshold, stable for the whole frame
//   frameConsumed  1-cycle pulse in EVAL, capture may overwrite memory
//   fpgaWakeIrq    sticky wake interrupt
//   timeoutErr     sticky watchdog flag
//   busy           high in every state except IDLE
//   frameCount     completed frames (EVAL or timeout), wrapping
module median_frame_scheduler #(
  parameter int unsigned INIT_CYCLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 40000,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned HIT_COUNT      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        frameReady,
  input  logic [12:0] thresholdIn,
  input  logic        thresholdLoad,
  input  logic        fullImageDone,
  input  logic        wakeUp,
  input  logic        ackIrq,
  output logic        filterInit,
  output logic        filterStart,
  output logic [12:0] threshold,
  output logic        frameConsumed,
  output logic        fpgaWakeIrq,
  output logic        timeoutErr,
  output logic        busy,
  output logic [15:0] frameCount
);

  // One shared down-phase counter serves INIT, RUN (watchdog) and GAP; the
  // sum of the three lengths bounds every value it must hold.
  localparam int unsigned CNT_W = $clog2(INIT_CYCLES + TIMEOUT_CYCLES + GAP_CYCLES + 1);

  localparam logic [CNT_W-1:0] INIT_LAST    = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    EVAL,
    GAP
  } stateT;

  stateT            state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       hitCnt;
  logic [4:0]       hitInc;
  logic [3:0]       hitNext;
  logic             hitReached;
  logic             irqSet;

  // Hit counter saturates at HIT_COUNT; reaching it in EVAL with wakeUp=1
  // raises the interrupt (again, if already set).
  always_comb begin
    hitInc     = {1'b0, hitCnt} + 5'd1;
    hitReached = (hitInc >= 5'(HIT_COUNT));
    hitNext    = hitReached ? 4'(HIT_COUNT) : hitInc[3:0];
    irqSet     = (state == EVAL) && wakeUp && hitReached;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      hitCnt        <= '0;
      filterInit    <= 1'b0;
      filterStart   <= 1'b0;
      threshold     <= '0;
      frameConsumed <= 1'b0;
      fpgaWakeIrq   <= 1'b0;
      timeoutErr    <= 1'b0;
      busy          <= 1'b0;
      frameCount    <= '0;
    end else begin
      frameConsumed <= 1'b0;

      // Set has priority over a coincident acknowledge.
      if (irqSet) begin
        fpgaWakeIrq <= 1'b1;
      end else if (ackIrq) begin
        fpgaWakeIrq <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (thresholdLoad) begin
            threshold <= thresholdIn;
          end
          if (enable && frameReady) begin
            state      <= INIT;
            filterInit <= 1'b1;
            busy       <= 1'b1;
            cnt        <= '0;
          end
        end

        INIT: begin
          if (cnt == INIT_LAST) begin
            state       <= RUN;
            filterInit  <= 1'b0;
            filterStart <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RUN: begin
          // Completion beats the watchdog when both land on the same cycle.
          if (fullImageDone) begin
            state         <= EVAL;
            frameConsumed <= 1'b1;
          end else if (cnt == TIMEOUT_LAST) begin
            state       <= GAP;
            filterStart <= 1'b0;
            timeoutErr  <= 1'b1;
            frameCount  <= frameCount + 16'd1;
            hitCnt      <= '0;
            cnt         <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        EVAL: begin
          state       <= GAP;
          filterStart <= 1'b0;
          frameCount  <= frameCount + 16'd1;
          hitCnt      <= wakeUp ? hitNext : '0;
          cnt         <= '0;
        end

        GAP: begin
          if (cnt == GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state       <= IDLE;
          filterInit  <= 1'b0;
          filterStart <= 1'b0;
          busy        <= 1'b0;
          cnt         <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_median_frame_scheduler.sv
// tb_median_frame_scheduler
//   Directed bench for median_frame_scheduler. Each frame task pushes the
//   expected end-of-frame state into a queue; a monitor pops and compares it
//   when filterStart falls (EVAL done or watchdog), and also checks the
//   filterInit and frameConsumed pulse widths of that frame.
module tb_median_frame_scheduler;

  localparam int INIT_C    = 4;
  localparam int TIMEOUT_C = 40000;
  localparam int GAP_C     = 16;
  localparam int HIT_C     = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        frameReady;
  logic [12:0] thresholdIn;
  logic        thresholdLoad;
  logic        fullImageDone;
  logic        wakeUp;
  logic        ackIrq;
  logic        filterInit;
  logic        filterStart;
  logic [12:0] threshold;
  logic        frameConsumed;
  logic        fpgaWakeIrq;
  logic        timeoutErr;
  logic        busy;
  logic [15:0] frameCount;

  always #5 clk = ~clk;

  median_frame_scheduler #(
    .INIT_CYCLES   (INIT_C),
    .TIMEOUT_CYCLES(TIMEOUT_C),
    .GAP_CYCLES    (GAP_C),
    .HIT_COUNT     (HIT_C)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .frameReady   (frameReady),
    .thresholdIn  (thresholdIn),
    .thresholdLoad(thresholdLoad),
    .fullImageDone(fullImageDone),
    .wakeUp       (wakeUp),
    .ackIrq       (ackIrq),
    .filterInit   (filterInit),
    .filterStart  (filterStart),
    .threshold    (threshold),
    .frameConsumed(frameConsumed),
    .fpgaWakeIrq  (fpgaWakeIrq),
    .timeoutErr   (timeoutErr),
    .busy         (busy),
    .frameCount   (frameCount)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned count;
    bit          irq;
    bit          tErr;
    logic [12:0] thr;
    int          consumed;
  } expT;

  expT expQ[$];

  // Reference model state
  int unsigned mCount = 0;
  bit          mIrq   = 1'b0;
  bit          mErr   = 1'b0;
  int          mHit   = 0;
  logic [12:0] mThr   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor
  bit prevStart = 1'b0;
  int initCnt   = 0;
  int consCnt   = 0;

  always @(negedge clk) begin
    expT e;
    if (!reset) begin
      prevStart = 1'b0;
      initCnt   = 0;
      consCnt   = 0;
    end else begin
      if (filterInit)    initCnt++;
      if (frameConsumed) consCnt++;
      if (prevStart && !filterStart) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frameEnd: frame ended with no expectation queued");
        end else begin
          e = expQ.pop_front();
          chk("frameCount",    32'(frameCount),  32'(e.count));
          chk("fpgaWakeIrq",   32'(fpgaWakeIrq), 32'(e.irq));
          chk("timeoutErr",    32'(timeoutErr),  32'(e.tErr));
          chk("threshold",     32'(threshold),   32'(e.thr));
          chk("consumedWidth", 32'(consCnt),     32'(e.consumed));
          chk("initWidth",     32'(initCnt),     32'(INIT_C));
          chk("busyInGap",     32'(busy),        32'd1);
        end
        initCnt = 0;
        consCnt = 0;
      end
      prevStart = filterStart;
    end
  end

  // doneAfter < 0 means the engine never finishes (watchdog frame).
  task automatic runFrame(input int doneAfter, input bit wake, input bit ackEval, input bit loadInRun);
    expT e;
    int  n;
    if (doneAfter < 0) begin
      mErr = 1'b1;
      mHit = 0;
      e.consumed = 0;
    end else begin
      if (wake) mHit = (mHit + 1 >= HIT_C) ? HIT_C : mHit + 1;
      else      mHit = 0;
      if (wake && mHit >= HIT_C) mIrq = 1'b1;
      else if (ackEval)          mIrq = 1'b0;
      e.consumed = 1;
    end
    mCount  = (mCount + 1) & 32'hFFFF;
    e.count = mCount;
    e.irq   = mIrq;
    e.tErr  = mErr;
    e.thr   = mThr;
    expQ.push_back(e);

    frameReady = 1'b1;
    n = 0;
    while (!filterStart && n < 20) begin
      tick();
      n++;
      if (busy) frameReady = 1'b0;
    end
    frameReady = 1'b0;
    chk("startLatency", 32'(n), 32'(1 + INIT_C));

    if (doneAfter < 0) begin
      n = 0;
      while (filterStart && n < TIMEOUT_C + 100) begin
        tick();
        n++;
      end
      chk("watchdogCycles", 32'(n), 32'(TIMEOUT_C));
    end else begin
      if (loadInRun) begin
        thresholdIn   = 13'd4800;
        thresholdLoad = 1'b1;
        tick();
        thresholdLoad = 1'b0;
      end
      repeat (doneAfter) tick();
      fullImageDone = 1'b1;
      wakeUp        = wake;
      tick();
      fullImageDone = 1'b0;
      ackIrq        = ackEval;
      tick();
      ackIrq = 1'b0;
      wakeUp = 1'b0;
    end

    n = 0;
    while (busy && n < GAP_C + 20) begin
      tick();
      n++;
    end
    chk("gapCycles", 32'(n), 32'(GAP_C));
  endtask

  task automatic loadThreshold(input logic [12:0] v);
    thresholdIn   = v;
    thresholdLoad = 1'b1;
    tick();
    thresholdLoad = 1'b0;
    mThr = v;
    chk("thresholdLoad", 32'(threshold), 32'(v));
  endtask

  task automatic ackAlone();
    ackIrq = 1'b1;
    tick();
    ackIrq = 1'b0;
    mIrq = 1'b0;
    chk("ackClears", 32'(fpgaWakeIrq), 32'd0);
  endtask

  initial begin
    int n;
    reset         = 1'b0;
    enable        = 1'b1;
    frameReady    = 1'b0;
    thresholdIn   = '0;
    thresholdLoad = 1'b0;
    fullImageDone = 1'b0;
    wakeUp        = 1'b0;
    ackIrq        = 1'b0;
    #12;
    chk("rstBusy",  32'(busy),        32'd0);
    chk("rstCount", 32'(frameCount),  32'd0);
    chk("rstIrq",   32'(fpgaWakeIrq), 32'd0);
    reset = 1'b1;
    tick();

    // Asynchronous reset in the middle of RUN
    loadThreshold(13'd123);
    frameReady = 1'b1;
    n = 0;
    while (!filterStart && n < 20) begin
      tick();
      n++;
    end
    frameReady = 1'b0;
    repeat (10) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("asyncRstStart",     32'(filterStart),   32'd0);
    chk("asyncRstInit",      32'(filterInit),    32'd0);
    chk("asyncRstBusy",      32'(busy),          32'd0);
    chk("asyncRstThreshold", 32'(threshold),     32'd0);
    chk("asyncRstConsumed",  32'(frameConsumed), 32'd0);
    chk("asyncRstTimeout",   32'(timeoutErr),    32'd0);
    #10;
    reset = 1'b1;
    mThr  = '0;
    tick();

    // Basic frame with a threshold loaded in IDLE
    loadThreshold(13'd300);
    runFrame(100, 1'b0, 1'b0, 1'b0);

    // Load attempt during RUN is ignored; a later IDLE load takes effect
    runFrame(50, 1'b0, 1'b0, 1'b1);
    loadThreshold(13'd4800);

    // Non-consecutive wakes never fire, three in a row do
    runFrame(20, 1'b1, 1'b0, 1'b0);
    runFrame(20, 1'b1, 1'b0, 1'b0);
    runFrame(20, 1'b0, 1'b0, 1'b0);
    runFrame(20, 1'b1, 1'b0, 1'b0);
    runFrame(20, 1'b1, 1'b0, 1'b0);
    runFrame(20, 1'b0, 1'b0, 1'b0);
    runFrame(20, 1'b1, 1'b0, 1'b0);
    runFrame(20, 1'b1, 1'b0, 1'b0);
    runFrame(20, 1'b1, 1'b0, 1'b0);

    // Acknowledge alone clears; acknowledge coincident with the set loses
    ackAlone();
    runFrame(10, 1'b0, 1'b0, 1'b0);
    runFrame(10, 1'b1, 1'b0, 1'b0);
    runFrame(10, 1'b1, 1'b0, 1'b0);
    runFrame(10, 1'b1, 1'b1, 1'b0);
    ackAlone();

    // Watchdog clears the hit streak
    runFrame(10, 1'b0, 1'b0, 1'b0);
    runFrame(10, 1'b1, 1'b0, 1'b0);
    runFrame(10, 1'b1, 1'b0, 1'b0);
    runFrame(-1, 1'b0, 1'b0, 1'b0);
    runFrame(10, 1'b1, 1'b0, 1'b0);
    runFrame(10, 1'b1, 1'b0, 1'b0);

    // Disabled scheduler never leaves IDLE
    enable     = 1'b0;
    frameReady = 1'b1;
    repeat (8) tick();
    chk("disabledIdle", 32'(busy), 32'd0);
    frameReady = 1'b0;
    enable     = 1'b1;

    repeat (3) tick();
    chk("queueDrained", 32'(expQ.size()), 32'd0);
    chk("finalCount",   32'(frameCount),  32'(mCount));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
